// File: rtl/mbus_stat_pkg.sv
// Shared constants, access-kind enum and CTRL read-word helper for the
// mbus statistics register bank.
package mbus_stat_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [18:0] OFF_CTRL      = 19'd0;
  localparam logic [18:0] OFF_FIFO_BASE = 19'd1;
  localparam logic [18:0] OFF_PORT_BASE = 19'd5;

  // CTRL register bit positions
  localparam int unsigned CTRL_MODE      = 0;
  localparam int unsigned CTRL_CLR_ON_RD = 1;
  localparam int unsigned CTRL_CLR_ALL   = 2;

  // Number of async-FIFO error counters
  localparam int unsigned FIFO_ERR_NUM = 4;

  // Decoded kind of the current mbus access
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_WR   = 2'd1,
    ACC_RD   = 2'd2
  } acc_e;

  // CTRL read word: clear_all is a pulse and always reads back as 0
  function automatic logic [31:0] ctrl_word(input logic mode, input logic clr_on_rd);
    return {29'd0, 1'b0, clr_on_rd, mode};
  endfunction

endpackage

// File: rtl/stat_counter.sv
// Single saturating event counter with clear-on-read and clear-all.
// Priority: clear-all, then clear-on-read (keeping a same-cycle event),
// then plain increment.
module stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  input  logic             i_clr_rd,
  input  logic             i_clr_all,
  output logic [CNT_W-1:0] ov_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_next_s;

  // Next counter value following the clear/increment priority
  always_comb begin
    cnt_next_s = ov_cnt;
    if (i_clr_all) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (i_clr_rd && i_inc) begin
      cnt_next_s = CNT_W'(1);
    end else if (i_clr_rd) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (i_inc && (ov_cnt != CNT_MAX)) begin
      cnt_next_s = ov_cnt + CNT_W'(1);
    end else begin
      cnt_next_s = ov_cnt;
    end
  end

  // Counter state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_cnt <= {CNT_W{1'b0}};
    end else begin
      ov_cnt <= cnt_next_s;
    end
  end

endmodule

// File: rtl/mbus_stat_regbank.sv
// mbus register bank: TSN/TTE mode control plus per-port packet counters and
// FIFO error counters, with a one-cycle registered read response.
// Counter index k sits at offset k+1: FIFO errors first, then in/out pairs
// per port.
module mbus_stat_regbank
  import mbus_stat_pkg::*;
#(
  parameter int          NPORT     = 8,
  parameter int          CNT_W     = 32,
  parameter logic [18:0] BASE_ADDR = 19'd0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [31:0]      iv_wdata,
  input  logic [18:0]      iv_addr,
  input  logic             i_addr_fixed,
  input  logic             i_rd,
  output logic             o_wr,
  output logic [31:0]      ov_rdata,
  output logic [18:0]      ov_raddr,
  output logic             o_addr_fixed,
  output logic             o_tsn_or_tte,
  input  logic [NPORT-1:0] iv_inpkt_pulse,
  input  logic [NPORT-1:0] iv_outpkt_pulse,
  input  logic [3:0]       iv_fifo_err_pulse
);

  localparam int          NCNT     = FIFO_ERR_NUM + 2 * NPORT;
  localparam logic [18:0] LAST_OFF = 19'(FIFO_ERR_NUM + 2 * NPORT);

  logic [18:0]      off_s;
  logic             hit_s;
  acc_e             acc_s;
  logic             wr_s;
  logic             rd_s;
  logic             ctrl_wr_s;
  logic             ctrl_rd_s;
  logic             clr_all_s;
  logic             clr_on_rd_r;
  logic [NCNT-1:0]  inc_s;
  logic [NCNT-1:0]  sel_s;
  logic [CNT_W-1:0] cnt_s [NCNT];
  logic [31:0]      rdata_s;
  logic             unused_wdata_s;

  // Offsets below BASE_ADDR wrap to large values and fall out of range
  assign off_s = iv_addr - BASE_ADDR;
  assign hit_s = !i_addr_fixed && (off_s <= LAST_OFF);

  // Classify the access; a write in the same cycle suppresses the read
  always_comb begin
    acc_s = ACC_NONE;
    if (!hit_s) begin
      acc_s = ACC_NONE;
    end else if (i_wr) begin
      acc_s = ACC_WR;
    end else if (i_rd) begin
      acc_s = ACC_RD;
    end else begin
      acc_s = ACC_NONE;
    end
  end

  assign wr_s      = (acc_s == ACC_WR);
  assign rd_s      = (acc_s == ACC_RD);
  assign ctrl_wr_s = wr_s && (off_s == OFF_CTRL);
  assign ctrl_rd_s = rd_s && (off_s == OFF_CTRL);
  assign clr_all_s = ctrl_wr_s && iv_wdata[CTRL_CLR_ALL];

  assign unused_wdata_s = ^iv_wdata[31:3];

  assign inc_s[FIFO_ERR_NUM-1:0] = iv_fifo_err_pulse;

  for (genvar p = 0; p < NPORT; p++) begin : g_port_inc
    assign inc_s[FIFO_ERR_NUM + 2*p]     = iv_inpkt_pulse[p];
    assign inc_s[FIFO_ERR_NUM + 2*p + 1] = iv_outpkt_pulse[p];
  end

  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    assign sel_s[k] = rd_s && (off_s == (OFF_FIFO_BASE + 19'(k)));

    stat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_inc     (inc_s[k]),
      .i_clr_rd  (sel_s[k] && clr_on_rd_r),
      .i_clr_all (clr_all_s),
      .ov_cnt    (cnt_s[k])
    );
  end

  // Read-data mux: one-hot OR of the selected register, zero when idle
  always_comb begin
    rdata_s = ctrl_rd_s ? ctrl_word(o_tsn_or_tte, clr_on_rd_r) : 32'd0;
    for (int k = 0; k < NCNT; k++) begin
      rdata_s = rdata_s | (sel_s[k] ? 32'(cnt_s[k]) : 32'd0);
    end
  end

  // CTRL register: mode and clear-on-read enable
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tsn_or_tte <= 1'b1;
      clr_on_rd_r  <= 1'b0;
    end else if (ctrl_wr_s) begin
      o_tsn_or_tte <= iv_wdata[CTRL_MODE];
      clr_on_rd_r  <= iv_wdata[CTRL_CLR_ON_RD];
    end else begin
      o_tsn_or_tte <= o_tsn_or_tte;
      clr_on_rd_r  <= clr_on_rd_r;
    end
  end

  // Read response register: valid and data drop to zero when no read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr         <= 1'b0;
      ov_rdata     <= 32'd0;
      ov_raddr     <= 19'd0;
      o_addr_fixed <= 1'b0;
    end else begin
      o_wr     <= rd_s;
      ov_rdata <= rdata_s;
      if (rd_s) begin
        ov_raddr     <= iv_addr;
        o_addr_fixed <= i_addr_fixed;
      end else begin
        ov_raddr     <= ov_raddr;
        o_addr_fixed <= o_addr_fixed;
      end
    end
  end

endmodule

// File: tb/tb_mbus_stat_regbank.sv
// Directed bench for mbus_stat_regbank (NPORT=8, CNT_W=8, non-zero base).
// Reads push their expected response onto a queue; every clock the response
// port is compared against the queue head or against "no response".
module tb_mbus_stat_regbank;

  localparam int          NPORT = 8;
  localparam int          CNT_W = 8;
  localparam logic [18:0] BASE  = 19'h00400;

  logic             clk;
  logic             rst_n;
  logic             i_wr;
  logic [31:0]      iv_wdata;
  logic [18:0]      iv_addr;
  logic             i_addr_fixed;
  logic             i_rd;
  logic             o_wr;
  logic [31:0]      ov_rdata;
  logic [18:0]      ov_raddr;
  logic             o_addr_fixed;
  logic             o_tsn_or_tte;
  logic [NPORT-1:0] iv_inpkt_pulse;
  logic [NPORT-1:0] iv_outpkt_pulse;
  logic [3:0]       iv_fifo_err_pulse;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q [$];
  logic [18:0] exp_addr_q [$];
  string       exp_tag_q  [$];

  mbus_stat_regbank #(
    .NPORT     (NPORT),
    .CNT_W     (CNT_W),
    .BASE_ADDR (BASE)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_wr              (i_wr),
    .iv_wdata          (iv_wdata),
    .iv_addr           (iv_addr),
    .i_addr_fixed      (i_addr_fixed),
    .i_rd              (i_rd),
    .o_wr              (o_wr),
    .ov_rdata          (ov_rdata),
    .ov_raddr          (ov_raddr),
    .o_addr_fixed      (o_addr_fixed),
    .o_tsn_or_tte      (o_tsn_or_tte),
    .iv_inpkt_pulse    (iv_inpkt_pulse),
    .iv_outpkt_pulse   (iv_outpkt_pulse),
    .iv_fifo_err_pulse (iv_fifo_err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_wr              = 1'b0;
    i_rd              = 1'b0;
    iv_wdata          = 32'd0;
    iv_addr           = 19'd0;
    i_addr_fixed      = 1'b0;
    iv_inpkt_pulse    = '0;
    iv_outpkt_pulse   = '0;
    iv_fifo_err_pulse = 4'd0;
  endtask

  // Compare the response port with the queue head, or expect silence
  task automatic check_resp();
    logic [31:0] ed;
    logic [18:0] ea;
    string       et;
    if (exp_data_q.size() > 0) begin
      ed = exp_data_q.pop_front();
      ea = exp_addr_q.pop_front();
      et = exp_tag_q.pop_front();
      checks++;
      assert (o_wr === 1'b1 && ov_rdata === ed && ov_raddr === ea && o_addr_fixed === 1'b0)
      else begin
        errors++;
        $error("FAIL %s: o_wr=%0b rdata=%h raddr=%h afix=%0b, required o_wr=1 rdata=%h raddr=%h afix=0",
               et, o_wr, ov_rdata, ov_raddr, o_addr_fixed, ed, ea);
      end
    end else begin
      checks++;
      assert (o_wr === 1'b0 && ov_rdata === 32'd0)
      else begin
        errors++;
        $error("FAIL no_resp: o_wr=%0b rdata=%h, required o_wr=0 rdata=0", o_wr, ov_rdata);
      end
    end
  endtask

  // One clock: sample just after the edge, then return inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    check_resp();
    idle_inputs();
  endtask

  task automatic rd(input int off, input logic [31:0] exp, input string tag);
    iv_addr = BASE + 19'(off);
    i_rd    = 1'b1;
    exp_data_q.push_back(exp);
    exp_addr_q.push_back(BASE + 19'(off));
    exp_tag_q.push_back(tag);
    tick();
  endtask

  task automatic rd_none(input logic [18:0] addr, input logic fixed);
    iv_addr      = addr;
    i_addr_fixed = fixed;
    i_rd         = 1'b1;
    tick();
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    iv_addr  = BASE + 19'(off);
    iv_wdata = d;
    i_wr     = 1'b1;
    tick();
  endtask

  task automatic chk_mode(input logic exp, input string tag);
    checks++;
    assert (o_tsn_or_tte === exp)
    else begin
      errors++;
      $error("FAIL %s: o_tsn_or_tte=%0b, required %0b", tag, o_tsn_or_tte, exp);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    // Reset values
    checks++;
    assert (o_wr === 1'b0 && ov_rdata === 32'd0 && ov_raddr === 19'd0 &&
            o_addr_fixed === 1'b0 && o_tsn_or_tte === 1'b1)
    else begin
      errors++;
      $error("FAIL reset: o_wr=%0b rdata=%h raddr=%h afix=%0b mode=%0b, required 0/0/0/0/1",
             o_wr, ov_rdata, ov_raddr, o_addr_fixed, o_tsn_or_tte);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // CTRL after reset, then silence on the following cycle
    rd(0, 32'h1, "ctrl_reset");
    tick();

    // inpkt port 3 counts 5 events
    for (int i = 0; i < 5; i++) begin
      iv_inpkt_pulse = 8'h08;
      tick();
    end
    rd(11, 32'd5, "inpkt3");
    rd(12, 32'd0, "outpkt3");
    rd(20, 32'd0, "outpkt7_last");

    // rx ovf saturates at 255
    for (int i = 0; i < 300; i++) begin
      iv_fifo_err_pulse = 4'b0001;
      tick();
    end
    rd(1, 32'd255, "rxovf_sat");

    // Clear-on-read with a coincident event
    wr(0, 32'h2);
    chk_mode(1'b0, "mode_after_wr2");
    for (int i = 0; i < 3; i++) begin
      iv_outpkt_pulse = 8'h01;
      tick();
    end
    iv_outpkt_pulse = 8'h01;
    rd(6, 32'd3, "cor_first");
    rd(6, 32'd1, "cor_second");
    rd(0, 32'h2, "ctrl_cor");
    rd(11, 32'd5, "cor_inpkt3");
    rd(11, 32'd0, "cor_inpkt3_clr");

    // clear_all discards coincident events and writes bits 0/1
    for (int i = 0; i < 2; i++) begin
      iv_fifo_err_pulse = 4'b0010;
      tick();
    end
    iv_inpkt_pulse = 8'hFF;
    wr(0, 32'h4);
    rd(1, 32'd0, "clrall_rxovf");
    rd(2, 32'd0, "clrall_rxunf");
    rd(5, 32'd0, "clrall_inpkt0");
    rd(0, 32'h0, "clrall_ctrl");
    for (int i = 0; i < 2; i++) begin
      iv_inpkt_pulse = 8'h01;
      tick();
    end
    rd(5, 32'd2, "noclr_first");
    rd(5, 32'd2, "noclr_second");
    wr(5, 32'hFF);
    rd(5, 32'd2, "cnt_wr_ignored");

    // Mode back to TSN
    wr(0, 32'h1);
    chk_mode(1'b1, "mode_wr1");
    rd(0, 32'h1, "ctrl_mode1");

    // Requests that must be ignored
    rd_none(BASE + 19'd20, 1'b1);
    rd_none(BASE + 19'd21, 1'b0);
    rd_none(BASE + 19'd22, 1'b0);
    rd_none(BASE - 19'd1, 1'b0);
    i_addr_fixed = 1'b1;
    wr(0, 32'h0);
    chk_mode(1'b1, "fixed_wr_ignored");

    // Simultaneous write and read: write wins, no response
    iv_addr  = BASE;
    iv_wdata = 32'h0;
    i_wr     = 1'b1;
    i_rd     = 1'b1;
    tick();
    chk_mode(1'b0, "wr_rd_collision");

    // Reset in the middle of a response
    rd(5, 32'd2, "pre_reset");
    rst_n = 1'b0;
    #1;
    checks++;
    assert (o_wr === 1'b0 && ov_rdata === 32'd0 && o_tsn_or_tte === 1'b1)
    else begin
      errors++;
      $error("FAIL mid_reset: o_wr=%0b rdata=%h mode=%0b, required 0/0/1", o_wr, ov_rdata, o_tsn_or_tte);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(5, 32'd0, "post_reset_cnt");
    rd(0, 32'h1, "post_reset_ctrl");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
